f_pc_ctrl: RTL and testbench

Fetch-stage PC controller for the pipelined MIPS core, superseding the purely combinational next-PC selector. It holds the architectural fetch PC register and resolves the next PC from sequential fetch, D-stage branch/jump/jr redirects, stalls, exception entry, and `eret` return. It also holds the EPC register and flags misaligned or out-of-range fetch addresses. It sits between the hazard unit, the D-stage comparator and control, the CP0/exception logic, and the instruction memory address port.

---
 rtl/f_pc_ctrl_if.sv | 36 +++
 rtl/f_pc_ctrl.sv | 115 +++++++++++
 tb/tb_f_pc_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/f_pc_ctrl_if.sv
// Fetch PC controller bus.
// Groups every signal between the fetch PC controller and its neighbours:
//   hazard unit    : stall
//   D stage        : npc_op, br_taken, d_pc, imm26, ra
//   CP0/exceptions : exc_req, exc_epc, epc_we, epc_wdata
//   controller out : pc, epc, f_adel, eret_accept, redirect
// master = surrounding pipeline (drives requests); slave = f_pc_ctrl.
interface f_pc_ctrl_if;
  logic        stall;
  logic [2:0]  npc_op;
  logic        br_taken;
  logic [31:0] d_pc;
  logic [25:0] imm26;
  logic [31:0] ra;
  logic        exc_req;
  logic [31:0] exc_epc;
  logic        epc_we;
  logic [31:0] epc_wdata;
  logic [31:0] pc;
  logic [31:0] epc;
  logic        f_adel;
  logic        eret_accept;
  logic        redirect;

  modport master (
    output stall, npc_op, br_taken, d_pc, imm26, ra,
    output exc_req, exc_epc, epc_we, epc_wdata,
    input  pc, epc, f_adel, eret_accept, redirect
  );

  modport slave (
    input  stall, npc_op, br_taken, d_pc, imm26, ra,
    input  exc_req, exc_epc, epc_we, epc_wdata,
    output pc, epc, f_adel, eret_accept, redirect
  );
endinterface

// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC controller.
// Holds the fetch PC and EPC registers and picks the next PC from sequential
// fetch, D-stage branch/jump/jr redirects, stall, exception entry and eret.
// Also flags misaligned or out-of-window fetch addresses.
// Ports:
//   clk     : clock, all state updates on the rising edge
//   reset_n : synchronous active-low reset
//   bus     : f_pc_ctrl_if.slave (D-stage op, CP0 controls, pc/epc/status out)
module f_pc_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_BYTES   = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset_n,
  f_pc_ctrl_if.slave  bus
);

  localparam logic [2:0] OpBr   = 3'd1;
  localparam logic [2:0] OpJal  = 3'd2;
  localparam logic [2:0] OpJr   = 3'd3;
  localparam logic [2:0] OpEret = 3'd4;

  logic [31:0] r_pc;
  logic [31:0] r_epc;

  logic [31:0] w_pc_next;
  logic [31:0] w_epc_next;
  logic [31:0] w_seq;
  logic [31:0] w_d_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic        w_redirect;
  logic        w_eret;
  logic        w_below;
  logic [31:0] w_off;

  // Redirect targets.
  assign w_seq        = r_pc + 32'd4;
  assign w_d_pc_plus4 = bus.d_pc + 32'd4;
  assign w_br_off     = {{14{bus.imm26[15]}}, bus.imm26[15:0], 2'b00};
  assign w_br_tgt     = w_d_pc_plus4 + w_br_off;
  assign w_j_tgt      = {w_d_pc_plus4[31:28], bus.imm26, 2'b00};

  // Next-PC selection. Exception beats stall; stall hides the D op, which
  // will be re-presented once the freeze lifts.
  always_comb begin
    w_pc_next  = w_seq;
    w_redirect = 1'b0;
    w_eret     = 1'b0;
    if (bus.exc_req) begin
      w_pc_next  = EXC_VECTOR;
      w_redirect = 1'b1;
    end else if (bus.stall) begin
      w_pc_next  = r_pc;
    end else begin
      case (bus.npc_op)
        OpEret: begin
          w_pc_next  = r_epc;   // old EPC even if mtc0 writes it this cycle
          w_redirect = 1'b1;
          w_eret     = 1'b1;
        end
        OpBr: begin
          if (bus.br_taken) begin
            w_pc_next  = w_br_tgt;
            w_redirect = 1'b1;
          end
        end
        OpJal: begin
          w_pc_next  = w_j_tgt;
          w_redirect = 1'b1;
        end
        OpJr: begin
          w_pc_next  = bus.ra;
          w_redirect = 1'b1;
        end
        default: w_pc_next = w_seq;
      endcase
    end
  end

  // EPC: exception capture wins over a same-cycle mtc0 write.
  always_comb begin
    w_epc_next = r_epc;
    if (bus.exc_req) begin
      w_epc_next = bus.exc_epc & ~32'd3;
    end else if (bus.epc_we) begin
      w_epc_next = bus.epc_wdata & ~32'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc  <= RESET_PC;
      r_epc <= 32'd0;
    end else begin
      r_pc  <= w_pc_next;
      r_epc <= w_epc_next;
    end
  end

  // Fetch fault check; the offset compare only matters when pc >= IM_BASE.
  assign w_below = (r_pc < IM_BASE);
  assign w_off   = r_pc - IM_BASE;

  assign bus.pc          = r_pc;
  assign bus.epc         = r_epc;
  assign bus.f_adel      = (r_pc[1:0] != 2'b00) | w_below | (!w_below && (w_off >= IM_BYTES));
  // Reset wins the edge, so no redirect is reported while it is asserted.
  assign bus.redirect    = w_redirect & reset_n;
  assign bus.eret_accept = w_eret & reset_n;

endmodule

// File: tb/tb_f_pc_ctrl.sv
module tb_f_pc_ctrl;

  logic clk;
  logic reset_n;

  f_pc_ctrl_if bus ();

  f_pc_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [2:0]  op;
    logic        br;
    logic [31:0] d_pc;
    logic [25:0] imm26;
    logic [31:0] ra;
    logic        exc;
    logic [31:0] exc_epc;
    logic        we;
    logic [31:0] wdata;
    logic        e_red;
    logic        e_eret;
    logic [31:0] e_pc;
    logic [31:0] e_epc;
    logic        e_adel;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  vec_t vecs[24];
  int   n_vecs;

  function automatic vec_t mk(
    input logic stall, input logic [2:0] op, input logic br, input logic [31:0] d_pc,
    input logic [25:0] imm26, input logic [31:0] ra, input logic exc,
    input logic [31:0] exc_epc, input logic we, input logic [31:0] wdata,
    input logic e_red, input logic e_eret, input logic [31:0] e_pc,
    input logic [31:0] e_epc, input logic e_adel);
    vec_t v;
    v.stall = stall; v.op = op; v.br = br; v.d_pc = d_pc; v.imm26 = imm26; v.ra = ra;
    v.exc = exc; v.exc_epc = exc_epc; v.we = we; v.wdata = wdata;
    v.e_red = e_red; v.e_eret = e_eret; v.e_pc = e_pc; v.e_epc = e_epc; v.e_adel = e_adel;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.npc_op = 0; bus.br_taken = 0; bus.d_pc = 0; bus.imm26 = 0;
    bus.ra = 0; bus.exc_req = 0; bus.exc_epc = 0; bus.epc_we = 0; bus.epc_wdata = 0;
  endtask

  task automatic apply(input vec_t v);
    bus.stall = v.stall; bus.npc_op = v.op; bus.br_taken = v.br; bus.d_pc = v.d_pc;
    bus.imm26 = v.imm26; bus.ra = v.ra; bus.exc_req = v.exc; bus.exc_epc = v.exc_epc;
    bus.epc_we = v.we; bus.epc_wdata = v.wdata;
  endtask

  initial begin
    // Table: each row runs one cycle starting from the previous row's pc (0x3008 first).
    n_vecs = 0;
    //                   stl op br d_pc        imm26         ra            exc exc_epc      we wdata         red er pc            epc           adel
    vecs[n_vecs++] = mk(0, 1, 1, 32'h3010, 26'h000FFFE, 32'h0,       0, 32'h0,    0, 32'h0,    1, 0, 32'h300C,     32'h0,    0);
    vecs[n_vecs++] = mk(0, 1, 0, 32'h3010, 26'h000FFFE, 32'h0,       0, 32'h0,    0, 32'h0,    0, 0, 32'h3010,     32'h0,    0);
    vecs[n_vecs++] = mk(0, 2, 0, 32'h3020, 26'h0000C10, 32'h0,       0, 32'h0,    0, 32'h0,    1, 0, 32'h3040,     32'h0,    0);
    vecs[n_vecs++] = mk(0, 3, 0, 32'h0,    26'h0,       32'h5000,    0, 32'h0,    0, 32'h0,    1, 0, 32'h5000,     32'h0,    0);
    vecs[n_vecs++] = mk(1, 2, 0, 32'h3020, 26'h0000C10, 32'h0,       0, 32'h0,    0, 32'h0,    0, 0, 32'h5000,     32'h0,    0);
    vecs[n_vecs++] = mk(1, 2, 0, 32'h3020, 26'h0000C10, 32'h0,       0, 32'h0,    0, 32'h0,    0, 0, 32'h5000,     32'h0,    0);
    vecs[n_vecs++] = mk(1, 2, 0, 32'h3020, 26'h0000C10, 32'h0,       0, 32'h0,    0, 32'h0,    0, 0, 32'h5000,     32'h0,    0);
    vecs[n_vecs++] = mk(0, 2, 0, 32'h3020, 26'h0000C10, 32'h0,       0, 32'h0,    0, 32'h0,    1, 0, 32'h3040,     32'h0,    0);
    vecs[n_vecs++] = mk(1, 2, 0, 32'h3020, 26'h0000C10, 32'h0,       1, 32'h3023, 0, 32'h0,    1, 0, 32'h4180,     32'h3020, 0);
    vecs[n_vecs++] = mk(0, 0, 0, 32'h0,    26'h0,       32'h0,       0, 32'h0,    0, 32'h0,    0, 0, 32'h4184,     32'h3020, 0);
    vecs[n_vecs++] = mk(0, 4, 0, 32'h0,    26'h0,       32'h0,       0, 32'h0,    0, 32'h0,    1, 1, 32'h3020,     32'h3020, 0);
    vecs[n_vecs++] = mk(0, 0, 0, 32'h0,    26'h0,       32'h0,       0, 32'h0,    0, 32'h0,    0, 0, 32'h3024,     32'h3020, 0);
    vecs[n_vecs++] = mk(0, 0, 0, 32'h0,    26'h0,       32'h0,       1, 32'h3047, 1, 32'h1234, 1, 0, 32'h4180,     32'h3044, 0);
    vecs[n_vecs++] = mk(0, 0, 0, 32'h0,    26'h0,       32'h0,       0, 32'h0,    1, 32'h5007, 0, 0, 32'h4184,     32'h5004, 0);
    vecs[n_vecs++] = mk(0, 4, 0, 32'h0,    26'h0,       32'h0,       0, 32'h0,    1, 32'h6000, 1, 1, 32'h5004,     32'h6000, 0);
    vecs[n_vecs++] = mk(0, 3, 0, 32'h0,    26'h0,       32'h3002,    0, 32'h0,    0, 32'h0,    1, 0, 32'h3002,     32'h6000, 1);
    vecs[n_vecs++] = mk(0, 3, 0, 32'h0,    26'h0,       32'h7000,    0, 32'h0,    0, 32'h0,    1, 0, 32'h7000,     32'h6000, 1);
    vecs[n_vecs++] = mk(0, 3, 0, 32'h0,    26'h0,       32'h6FFC,    0, 32'h0,    0, 32'h0,    1, 0, 32'h6FFC,     32'h6000, 0);
    vecs[n_vecs++] = mk(0, 3, 0, 32'h0,    26'h0,       32'h2FFC,    0, 32'h0,    0, 32'h0,    1, 0, 32'h2FFC,     32'h6000, 1);
    vecs[n_vecs++] = mk(0, 5, 1, 32'h3010, 26'h0,       32'h0,       0, 32'h0,    0, 32'h0,    0, 0, 32'h3000,     32'h6000, 0);
    vecs[n_vecs++] = mk(0, 3, 0, 32'h0,    26'h0,       32'hFFFFFFFC, 0, 32'h0,   0, 32'h0,    1, 0, 32'hFFFFFFFC, 32'h6000, 1);
    vecs[n_vecs++] = mk(0, 7, 0, 32'h0,    26'h0,       32'h0,       0, 32'h0,    0, 32'h0,    0, 0, 32'h0,        32'h6000, 1);

    // Reset held for 2 cycles.
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", bus.pc, 32'h3000);
    check("reset_epc", bus.epc, 32'h0);
    check("reset_adel", {31'd0, bus.f_adel}, 32'd0);
    check("reset_redirect", {31'd0, bus.redirect}, 32'd0);
    check("reset_eret", {31'd0, bus.eret_accept}, 32'd0);

    // Sequential fetch.
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("seq_pc1", bus.pc, 32'h3004);
    @(posedge clk); #1;
    check("seq_pc2", bus.pc, 32'h3008);

    for (int i = 0; i < n_vecs; i++) begin
      apply(vecs[i]);
      #1;
      check($sformatf("v%0d_redirect", i), {31'd0, bus.redirect}, {31'd0, vecs[i].e_red});
      check($sformatf("v%0d_eret", i), {31'd0, bus.eret_accept}, {31'd0, vecs[i].e_eret});
      @(posedge clk); #1;
      check($sformatf("v%0d_pc", i), bus.pc, vecs[i].e_pc);
      check($sformatf("v%0d_epc", i), bus.epc, vecs[i].e_epc);
      check($sformatf("v%0d_adel", i), {31'd0, bus.f_adel}, {31'd0, vecs[i].e_adel});
    end

    // eret_accept lasts exactly one cycle when followed by sequential fetch.
    idle_inputs();
    bus.npc_op = 3'd4;
    #1;
    check("eret_pulse_hi", {31'd0, bus.eret_accept}, 32'd1);
    @(posedge clk); #1;
    check("eret_pulse_pc", bus.pc, 32'h6000);
    bus.npc_op = 3'd0;
    #1;
    check("eret_pulse_lo", {31'd0, bus.eret_accept}, 32'd0);
    @(posedge clk); #1;
    check("eret_pulse_seq", bus.pc, 32'h6004);

    // Reset asserted mid-stall with a pending jump.
    bus.stall = 1; bus.npc_op = 3'd2; bus.d_pc = 32'h3020; bus.imm26 = 26'h0000C10;
    @(posedge clk); #1;
    check("stall_hold", bus.pc, 32'h6004);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_stall_pc", bus.pc, 32'h3000);
    check("rst_stall_epc", bus.epc, 32'h0);

    // Reset asserted on a redirect edge.
    bus.stall = 0; bus.npc_op = 3'd3; bus.ra = 32'h5000;
    #1;
    check("rst_redir_flag", {31'd0, bus.redirect}, 32'd0);
    @(posedge clk); #1;
    check("rst_redir_pc", bus.pc, 32'h3000);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_jr", bus.pc, 32'h5000);
    idle_inputs();
    @(posedge clk); #1;
    check("post_rst_seq", bus.pc, 32'h5004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
